// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and helpers for the RV32M multiply/divide unit
package muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Default-width corner values; the unit derives its own for other XLEN
   localparam logic [XLEN_DEFAULT-1:0] MIN_NEG  = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};
   localparam logic [XLEN_DEFAULT-1:0] ALL_ONES = '1;

   function automatic logic op1_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic op2_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - sign correction and result select applied to unsigned iteration results
module muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [2*XLEN-1:0] product,
   input  logic [XLEN-1:0]   quotient,
   input  logic [XLEN-1:0]   remainder,
   input  logic              neg1,
   input  logic              neg2,
   input  logic [2:0]        funct3,
   output logic [XLEN-1:0]   result
);

   logic [2*XLEN-1:0] prod_fixed;

   always_comb begin
      prod_fixed = (neg1 ^ neg2) ? -product : product;
      result     = '0;
      if (!funct3[2]) begin
         result = (funct3 == F3_MUL) ? prod_fixed[XLEN-1:0] : prod_fixed[2*XLEN-1:XLEN];
      end else if (funct3[1]) begin
         // Remainder follows the dividend's sign
         result = neg1 ? -remainder : remainder;
      end else begin
         result = (neg1 ^ neg2) ? -quotient : quotient;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int CNT_W = $clog2(XLEN)
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic [2:0]      FUNCT3,
   input  logic [XLEN-1:0] OPERAND1,
   input  logic [XLEN-1:0] OPERAND2,
   input  logic            FLUSH,
   output logic            BUSY,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT
);

   localparam logic [XLEN-1:0]  X_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0]  X_ALL_ONES = '1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(XLEN - 1);

   logic [1:0]        state;
   logic [2:0]        funct3_q;
   logic              neg1_q;
   logic              neg2_q;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   b_q;
   logic [XLEN-1:0]   q_q;
   logic [XLEN:0]     r_q;
   logic [XLEN-1:0]   result_q;

   logic              in_neg1;
   logic              in_neg2;
   logic [XLEN-1:0]   abs1;
   logic [XLEN-1:0]   abs2;
   logic              div_zero;
   logic              div_ovf;
   logic [XLEN:0]     mul_sum;
   logic [XLEN+1:0]   div_diff;
   logic              div_ge;
   logic [XLEN-1:0]   fix_result;

   assign in_neg1  = op1_signed(FUNCT3) & OPERAND1[XLEN-1];
   assign in_neg2  = op2_signed(FUNCT3) & OPERAND2[XLEN-1];
   assign abs1     = in_neg1 ? -OPERAND1 : OPERAND1;
   assign abs2     = in_neg2 ? -OPERAND2 : OPERAND2;
   assign div_zero = FUNCT3[2] && (OPERAND2 == '0);
   assign div_ovf  = FUNCT3[2] && !FUNCT3[0] && (OPERAND1 == X_MIN_NEG) && (OPERAND2 == X_ALL_ONES);

   // Multiply: upper half plus multiplicand when the current multiplier bit (acc[0]) is set
   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
   // Divide: trial subtract of divisor from remainder shifted with the next dividend bit
   assign div_diff = {r_q, q_q[XLEN-1]} - {2'b00, b_q};
   assign div_ge   = !div_diff[XLEN+1];

   muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .product   (acc),
      .quotient  (q_q),
      .remainder (r_q[XLEN-1:0]),
      .neg1      (neg1_q),
      .neg2      (neg2_q),
      .funct3    (funct3_q),
      .result    (fix_result)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= ST_IDLE;
         funct3_q <= '0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         b_q      <= '0;
         q_q      <= '0;
         r_q      <= '0;
         result_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (START && !FLUSH) begin
                  funct3_q <= FUNCT3;
                  cnt      <= '0;
                  if (div_zero || div_ovf) begin
                     // Fast path: results are final, so sign correction is disabled
                     neg1_q <= 1'b0;
                     neg2_q <= 1'b0;
                     q_q    <= div_zero ? X_ALL_ONES : X_MIN_NEG;
                     r_q    <= div_zero ? {1'b0, OPERAND1} : '0;
                     state  <= ST_FIX;
                  end else begin
                     neg1_q <= in_neg1;
                     neg2_q <= in_neg2;
                     acc    <= {{XLEN{1'b0}}, abs2};
                     b_q    <= FUNCT3[2] ? abs2 : abs1;
                     q_q    <= abs1;
                     r_q    <= '0;
                     state  <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (FLUSH) begin
                  state <= ST_IDLE;
               end else begin
                  if (funct3_q[2]) begin
                     r_q <= div_ge ? div_diff[XLEN:0] : {r_q[XLEN-1:0], q_q[XLEN-1]};
                     q_q <= {q_q[XLEN-2:0], div_ge};
                  end else begin
                     acc <= {mul_sum, acc[XLEN-1:1]};
                  end
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST) begin
                     state <= ST_FIX;
                  end
               end
            end
            ST_FIX: begin
               if (FLUSH) begin
                  state <= ST_IDLE;
               end else begin
                  result_q <= fix_result;
                  state    <= ST_DONE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign BUSY   = (state != ST_IDLE);
   assign DONE   = (state == ST_DONE);
   assign RESULT = result_q;

endmodule
